// File: rtl/free_list_ctrl.sv
// Free-list controller: fills the physical-register stack after reset,
// then arbitrates dispatch allocations against buffered retire frees.
module free_list_ctrl #(
   parameter  int PHYS_REG_SZ    = 64,
   parameter  int ARCH_REG_SZ    = 32,
   parameter  int FREE_BUF_DEPTH = 4,
   localparam int TAG_W = $clog2(PHYS_REG_SZ),
   localparam int CNT_W = $clog2(PHYS_REG_SZ+FREE_BUF_DEPTH)+1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dispatch_req,
   output logic             alloc_gnt,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             retire_valid,
   input  logic [TAG_W-1:0] retire_tag,
   output logic             retire_ready,
   output logic             fl_push,
   output logic [TAG_W-1:0] fl_tag_in,
   output logic             fl_pop,
   input  logic [TAG_W-1:0] fl_tag_out,
   input  logic             fl_empty,
   input  logic             fl_full,
   output logic             init_done,
   output logic [CNT_W-1:0] free_count
);

   localparam int PTR_W = $clog2(FREE_BUF_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [TAG_W-1:0] r_init_ptr;
   logic [TAG_W-1:0] r_buf [FREE_BUF_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [OCC_W-1:0] r_occ;
   logic [CNT_W-1:0] r_free_count;
   logic             r_init_done;
   logic             r_retire_ready;

   logic             w_push;
   logic [TAG_W-1:0] w_tag_in;
   logic             w_pop;
   logic             w_gnt;
   logic [TAG_W-1:0] w_alloc_tag;
   logic             w_deq;
   logic             w_enq;
   logic [TAG_W-1:0] w_head;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_last_init;
   logic [OCC_W-1:0] w_occ_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign w_head       = r_buf[r_rd_ptr];
   assign w_fifo_full  = (r_occ == OCC_W'(FREE_BUF_DEPTH));
   assign w_fifo_empty = (r_occ == '0);
   assign w_last_init  = (r_init_ptr == TAG_W'(PHYS_REG_SZ-1));
   assign w_enq        = retire_valid & r_retire_ready;

   assign w_occ_nxt = r_occ + OCC_W'(w_enq) - OCC_W'(w_deq);
   assign w_cnt_nxt = r_free_count
                    + CNT_W'(w_enq)
                    + CNT_W'(r_state == S_INIT)
                    - CNT_W'(w_gnt);

   // Comb outputs are forced low while reset is held
   assign fl_push   = w_push & ~reset;
   assign fl_tag_in = reset ? '0 : w_tag_in;
   assign fl_pop    = w_pop & ~reset;
   assign alloc_gnt = w_gnt & ~reset;
   assign alloc_tag = reset ? '0 : w_alloc_tag;

   assign retire_ready = r_retire_ready;
   assign init_done    = r_init_done;
   assign free_count   = r_free_count;

   // Next state and prioritised stack/dispatch arbitration
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_tag_in    = '0;
      w_pop       = 1'b0;
      w_gnt       = 1'b0;
      w_alloc_tag = '0;
      w_deq       = 1'b0;
      unique case (r_state)
         S_INIT: begin
            w_push   = 1'b1;
            w_tag_in = r_init_ptr;
            if (w_last_init) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_fifo_full && !fl_full) begin
               w_push   = 1'b1;
               w_tag_in = w_head;
               w_deq    = 1'b1;
            end else if (dispatch_req && !fl_empty) begin
               w_pop       = 1'b1;
               w_gnt       = 1'b1;
               w_alloc_tag = fl_tag_out;
            end else if (dispatch_req && !w_fifo_empty) begin
               w_gnt       = 1'b1;
               w_alloc_tag = w_head;
               w_deq       = 1'b1;
            end else if (!w_fifo_empty && !fl_full) begin
               w_push   = 1'b1;
               w_tag_in = w_head;
               w_deq    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Walk the non-architectural tags during INIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_init_ptr <= TAG_W'(ARCH_REG_SZ);
      end else if (r_state == S_INIT) begin
         r_init_ptr <= r_init_ptr + TAG_W'(1);
      end
   end

   // Retire-free FIFO storage; contents only matter under r_occ
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_buf[r_wr_ptr] <= retire_tag;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_occ <= w_occ_nxt;
      end
   end

   // Free count, init flag and retire back-pressure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_free_count   <= '0;
         r_init_done    <= 1'b0;
         r_retire_ready <= 1'b0;
      end else begin
         r_free_count   <= w_cnt_nxt;
         r_init_done    <= (w_state_nxt == S_RUN);
         r_retire_ready <= (w_state_nxt == S_RUN) &&
                           (w_occ_nxt < OCC_W'(FREE_BUF_DEPTH));
      end
   end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl with a behavioural
// free-list stack attached to the fl_* ports.
module tb_free_list_ctrl;

   logic       clk;
   logic       reset;
   logic       dispatch_req;
   logic       alloc_gnt;
   logic [5:0] alloc_tag;
   logic       retire_valid;
   logic [5:0] retire_tag;
   logic       retire_ready;
   logic       fl_push;
   logic [5:0] fl_tag_in;
   logic       fl_pop;
   logic [5:0] fl_tag_out;
   logic       fl_empty;
   logic       fl_full;
   logic       init_done;
   logic [7:0] free_count;

   int total;
   int bad;

   logic [5:0] stk [64];
   logic [6:0] sp;

   free_list_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .dispatch_req (dispatch_req),
      .alloc_gnt    (alloc_gnt),
      .alloc_tag    (alloc_tag),
      .retire_valid (retire_valid),
      .retire_tag   (retire_tag),
      .retire_ready (retire_ready),
      .fl_push      (fl_push),
      .fl_tag_in    (fl_tag_in),
      .fl_pop       (fl_pop),
      .fl_tag_out   (fl_tag_out),
      .fl_empty     (fl_empty),
      .fl_full      (fl_full),
      .init_done    (init_done),
      .free_count   (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fl_tag_out = (sp != 7'd0) ? stk[6'(sp - 7'd1)] : 6'd0;
   assign fl_empty   = (sp == 7'd0);
   assign fl_full    = (sp == 7'd64);

   // Behavioural stack sharing clk/reset with the controller
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sp <= 7'd0;
      end else if (fl_push) begin
         stk[sp[5:0]] <= fl_tag_in;
         sp <= sp + 7'd1;
      end else if (fl_pop) begin
         sp <= sp - 7'd1;
      end
   end

   task automatic test_reset;
      reset = 1'b1;
      dispatch_req = 1'b0;
      retire_valid = 1'b0;
      retire_tag = 6'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (fl_push !== 1'b0) begin
         bad++;
         $display("FAIL rst_push got=%0b exp=0", fl_push);
      end
      total++;
      if (init_done !== 1'b0) begin
         bad++;
         $display("FAIL rst_done got=%0b exp=0", init_done);
      end
      total++;
      if (free_count !== 8'd0) begin
         bad++;
         $display("FAIL rst_count got=%0d exp=0", free_count);
      end
      total++;
      if (retire_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_ready got=%0b exp=0", retire_ready);
      end
      total++;
      if (alloc_gnt !== 1'b0 || fl_pop !== 1'b0) begin
         bad++;
         $display("FAIL rst_gnt_pop got=%0b%0b exp=00", alloc_gnt, fl_pop);
      end
   endtask

   task automatic test_init;
      logic [5:0] exp;
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         exp = 6'(32 + i);
         total++;
         if (fl_push !== 1'b1 || fl_tag_in !== exp) begin
            bad++;
            $display("FAIL init_push[%0d] got=%0b/%0d exp=1/%0d",
                     i, fl_push, fl_tag_in, exp);
         end
         total++;
         if (init_done !== 1'b0 || retire_ready !== 1'b0) begin
            bad++;
            $display("FAIL init_flags[%0d] got=%0b%0b exp=00",
                     i, init_done, retire_ready);
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (init_done !== 1'b1) begin
         bad++;
         $display("FAIL init_done got=%0b exp=1", init_done);
      end
      total++;
      if (free_count !== 8'd32) begin
         bad++;
         $display("FAIL init_count got=%0d exp=32", free_count);
      end
      total++;
      if (retire_ready !== 1'b1 || fl_push !== 1'b0) begin
         bad++;
         $display("FAIL init_end got=rdy%0b push%0b exp=rdy1 push0",
                  retire_ready, fl_push);
      end
      total++;
      if (sp !== 7'd32) begin
         bad++;
         $display("FAIL init_sp got=%0d exp=32", sp);
      end
   endtask

   task automatic test_alloc_one;
      dispatch_req = 1'b1;
      #1;
      total++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== 6'd63) begin
         bad++;
         $display("FAIL alloc_one got=%0b/%0d exp=1/63", alloc_gnt, alloc_tag);
      end
      total++;
      if (fl_pop !== 1'b1 || fl_push !== 1'b0) begin
         bad++;
         $display("FAIL alloc_pop got=pop%0b push%0b exp=pop1 push0",
                  fl_pop, fl_push);
      end
      @(negedge clk);
      dispatch_req = 1'b0;
      #1;
      total++;
      if (free_count !== 8'd31 || alloc_gnt !== 1'b0) begin
         bad++;
         $display("FAIL alloc_after got=%0d/%0b exp=31/0", free_count, alloc_gnt);
      end
      @(negedge clk);
   endtask

   task automatic test_retire_one;
      retire_valid = 1'b1;
      retire_tag = 6'd5;
      #1;
      total++;
      if (retire_ready !== 1'b1 || fl_push !== 1'b0) begin
         bad++;
         $display("FAIL ret_accept got=rdy%0b push%0b exp=rdy1 push0",
                  retire_ready, fl_push);
      end
      @(negedge clk);
      retire_valid = 1'b0;
      #1;
      total++;
      if (fl_push !== 1'b1 || fl_tag_in !== 6'd5) begin
         bad++;
         $display("FAIL ret_push got=%0b/%0d exp=1/5", fl_push, fl_tag_in);
      end
      total++;
      if (free_count !== 8'd32) begin
         bad++;
         $display("FAIL ret_count got=%0d exp=32", free_count);
      end
      @(negedge clk);
      #1;
      total++;
      if (fl_push !== 1'b0 || sp !== 7'd32 || fl_tag_out !== 6'd5) begin
         bad++;
         $display("FAIL ret_drained got=push%0b sp%0d top%0d exp=push0 sp32 top5",
                  fl_push, sp, fl_tag_out);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [5:0] exp;
      for (int i = 0; i < 4; i++) begin
         dispatch_req = 1'b1;
         retire_valid = 1'b1;
         retire_tag = 6'(10 + i);
         #1;
         exp = (i == 0) ? 6'd5 : 6'(63 - i);
         total++;
         if (alloc_gnt !== 1'b1 || alloc_tag !== exp || fl_pop !== 1'b1) begin
            bad++;
            $display("FAIL b2b_alloc[%0d] got=%0b/%0d/%0b exp=1/%0d/1",
                     i, alloc_gnt, alloc_tag, fl_pop, exp);
         end
         total++;
         if (retire_ready !== 1'b1 || fl_push !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready[%0d] got=rdy%0b push%0b exp=rdy1 push0",
                     i, retire_ready, fl_push);
         end
         @(negedge clk);
      end
      retire_tag = 6'd14;
      #1;
      total++;
      if (retire_ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_full_ready got=%0b exp=0", retire_ready);
      end
      total++;
      if (alloc_gnt !== 1'b0 || fl_pop !== 1'b0) begin
         bad++;
         $display("FAIL b2b_full_gnt got=%0b/%0b exp=0/0", alloc_gnt, fl_pop);
      end
      total++;
      if (fl_push !== 1'b1 || fl_tag_in !== 6'd10) begin
         bad++;
         $display("FAIL b2b_full_push got=%0b/%0d exp=1/10", fl_push, fl_tag_in);
      end
      @(negedge clk);
      dispatch_req = 1'b0;
      retire_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         exp = 6'(11 + j);
         total++;
         if (fl_push !== 1'b1 || fl_tag_in !== exp || retire_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drain[%0d] got=%0b/%0d/rdy%0b exp=1/%0d/rdy1",
                     j, fl_push, fl_tag_in, retire_ready, exp);
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (fl_push !== 1'b0 || free_count !== 8'd32 || sp !== 7'd32) begin
         bad++;
         $display("FAIL b2b_end got=push%0b cnt%0d sp%0d exp=push0 cnt32 sp32",
                  fl_push, free_count, sp);
      end
   endtask

   task automatic test_bypass;
      logic [5:0] exp;
      for (int i = 0; i < 32; i++) begin
         dispatch_req = 1'b1;
         #1;
         exp = (i < 4) ? 6'(13 - i) : 6'(59 - (i - 4));
         total++;
         if (alloc_gnt !== 1'b1 || alloc_tag !== exp) begin
            bad++;
            $display("FAIL drain_alloc[%0d] got=%0b/%0d exp=1/%0d",
                     i, alloc_gnt, alloc_tag, exp);
         end
         @(negedge clk);
      end
      dispatch_req = 1'b0;
      retire_valid = 1'b1;
      retire_tag = 6'd7;
      #1;
      total++;
      if (free_count !== 8'd0 || fl_empty !== 1'b1 || retire_ready !== 1'b1) begin
         bad++;
         $display("FAIL byp_empty got=cnt%0d emp%0b rdy%0b exp=cnt0 emp1 rdy1",
                  free_count, fl_empty, retire_ready);
      end
      @(negedge clk);
      retire_valid = 1'b0;
      dispatch_req = 1'b1;
      #1;
      total++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== 6'd7) begin
         bad++;
         $display("FAIL byp_gnt got=%0b/%0d exp=1/7", alloc_gnt, alloc_tag);
      end
      total++;
      if (fl_push !== 1'b0 || fl_pop !== 1'b0 || free_count !== 8'd1) begin
         bad++;
         $display("FAIL byp_noop got=push%0b pop%0b cnt%0d exp=push0 pop0 cnt1",
                  fl_push, fl_pop, free_count);
      end
      @(negedge clk);
      #1;
      total++;
      if (free_count !== 8'd0 || alloc_gnt !== 1'b0 || fl_pop !== 1'b0) begin
         bad++;
         $display("FAIL byp_starve got=cnt%0d gnt%0b pop%0b exp=cnt0 gnt0 pop0",
                  free_count, alloc_gnt, fl_pop);
      end
      dispatch_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_init;
      logic [5:0] exp;
      retire_valid = 1'b1;
      retire_tag = 6'd9;
      @(negedge clk);
      retire_valid = 1'b0;
      #1;
      total++;
      if (fl_push !== 1'b1 || fl_tag_in !== 6'd9) begin
         bad++;
         $display("FAIL mid_fifo got=%0b/%0d exp=1/9", fl_push, fl_tag_in);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp = 6'(32 + i);
         total++;
         if (fl_push !== 1'b1 || fl_tag_in !== exp) begin
            bad++;
            $display("FAIL mid_init[%0d] got=%0b/%0d exp=1/%0d",
                     i, fl_push, fl_tag_in, exp);
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (fl_tag_in !== 6'd42 || free_count !== 8'd10) begin
         bad++;
         $display("FAIL mid_c10 got=%0d/%0d exp=42/10", fl_tag_in, free_count);
      end
      reset = 1'b1;
      #1;
      total++;
      if (fl_push !== 1'b0 || fl_tag_in !== 6'd0 || free_count !== 8'd0) begin
         bad++;
         $display("FAIL mid_rst got=push%0b tag%0d cnt%0d exp=push0 tag0 cnt0",
                  fl_push, fl_tag_in, free_count);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         exp = 6'(32 + i);
         total++;
         if (fl_push !== 1'b1 || fl_tag_in !== exp) begin
            bad++;
            $display("FAIL reinit[%0d] got=%0b/%0d exp=1/%0d",
                     i, fl_push, fl_tag_in, exp);
         end
         @(negedge clk);
      end
      #1;
      total++;
      if (init_done !== 1'b1 || free_count !== 8'd32 || fl_push !== 1'b0) begin
         bad++;
         $display("FAIL reinit_end got=done%0b cnt%0d push%0b exp=done1 cnt32 push0",
                  init_done, free_count, fl_push);
      end
      total++;
      if (sp !== 7'd32 || fl_tag_out !== 6'd63) begin
         bad++;
         $display("FAIL reinit_stack got=sp%0d top%0d exp=sp32 top63", sp, fl_tag_out);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_init();
      test_alloc_one();
      test_retire_one();
      test_back_to_back();
      test_bypass();
      test_reset_mid_init();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
